// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and sizing helper for the piso_tx serial transmitter.
package piso_pkg;
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction
endpackage

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter, one bit per bit_en strobe with valid and done.
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   input  logic             bit_en,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);
   localparam int CW = cnt_width(WIDTH);
   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             last;
   assign last = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && load) begin
            state <= SHIFT;
            sreg  <= din;
            cnt   <= '0;
         end else if (state == SHIFT && bit_en) begin
            if (last) begin
               state <= IDLE;
               done  <= 1'b1;
            end else begin
               sreg <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
            end
         end
      end
   end
   // Outputs decode registered state only, so no input reaches them combinationally.
   assign ready      = state == IDLE;
   assign sout_valid = state == SHIFT;
   assign sout       = sout_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter for the digital-fundamentals series: accepts a WIDTH-bit word on a load strobe and shifts it out one bit per bit-enable strobe on a single serial line, with a valid qualifier and a completion pulse. It is the driving end of a serial bit stream whose receiving end is a chain of sampling flip-flops. The bit rate is set externally through `bit_en`: tie it high for one bit per clock, or drive it from a divider for slow, LED-visible shifting.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `din`  in  WIDTH  parallel word; sampled only on an accepted load.
- `load`  in  1  load request; accepted only when `ready`=1.
- `bit_en`  in  1  bit-advance strobe; one high cycle ends the current bit.
- `ready`  out  1  high in IDLE; block can accept a load.
- `sout`  out  1  serial data; 0 when not transmitting.
- `sout_valid`  out  1  high while `sout` carries a data bit.
- `done`  out  1  one-cycle pulse after the last bit completes.

## Operation
- Reset values: state=IDLE, shift register=0, bit counter=0, `ready`=1, `sout`=0, `sout_valid`=0, `done`=0.
- Two states, IDLE and SHIFT.
- IDLE:
  - `ready`=1, `sout`=0, `sout_valid`=0.
  - `load`=1 at an edge: capture `din` into the shift register, clear the counter, go to SHIFT.
- SHIFT:
  - `ready`=0, `sout_valid`=1.
  - `sout` = shift register bit WIDTH-1 if MSB_FIRST=1, else bit 0.
- Edge in SHIFT with `bit_en`=1:
  - If counter = WIDTH-1: go to IDLE and assert `done` for the next cycle.
  - Otherwise: shift the register one position toward the output end, fill the vacated bit with 0, and increment the counter.
- Edge in SHIFT with `bit_en`=0: hold all state; the current bit stays on `sout`.
- `load` in SHIFT is ignored, and `din` is not sampled.
- `bit_en` in IDLE is ignored.
- Counter width is $clog2(WIDTH); it never exceeds WIDTH-1 and never wraps.
- `rst` has priority over `load` and `bit_en` in every state.
- `rst` during SHIFT: the word in flight is abandoned, outputs return to reset values on the next edge, and no `done` pulse is produced.

## Timing
- Load accepted at edge E0. The first bit appears on `sout`, with `sout_valid`=1, in the cycle after E0.
- Each bit is held until the first edge with `bit_en`=1, then the next bit appears.
- With `bit_en` tied high, bit k occupies cycle E0+1+k for k=0..WIDTH-1.
- `done`=1 and `ready`=1 in cycle E0+WIDTH+1 (bit_en tied high).
- `sout` and `sout_valid` are registered; no combinational path from inputs to outputs.
- Back-to-back words: a `load` sampled in the `done` cycle is accepted. Minimum gap between words is one idle cycle, so the word period is WIDTH+1 cycles.
- `done` never coincides with `sout_valid`=1.

## Structure
- Shared package `piso_pkg`:
  - state enum {IDLE, SHIFT};
  - function computing the counter width from WIDTH.
- Single module, no sub-module.
- Shift register, counter and state register live inline in `piso_tx`.
- All outputs are decoded from registered state. `done` is its own register, set on the final-bit transition and cleared on the next edge.

## Test plan
- Reset then idle: hold `rst`=1 for 3 cycles, release → `ready`=1, `sout`=0, `sout_valid`=0, `done`=0; `bit_en` toggling causes no change.
- Basic word: WIDTH=8, MSB_FIRST=1, `bit_en`=1, load `din`=8'hA5 → `sout` = 1,0,1,0,0,1,0,1 on cycles 1..8 with `sout_valid`=1; `done`=1 and `ready`=1 in cycle 9.
- LSB-first with throttling: MSB_FIRST=0, `bit_en` high every 4th cycle, load 8'h3C → bits 0,0,1,1,1,1,0,0, each held exactly 4 cycles; single `done` pulse after the 8th bit.
- Ignored load and back-to-back: re-assert `load` with 8'hFF mid-word → the first word is unaltered. Load 8'h81 in the `done` cycle → 1,0,0,0,0,0,0,1 starts on the next cycle.
- Reset mid-word: assert `rst` after the 3rd bit → next cycle has `sout_valid`=0, `sout`=0, `ready`=1, and no `done` pulse follows.
- Width edge: WIDTH=2, load 2'b10 with `bit_en` tied high → `sout` 1 then 0 over 2 cycles, `done` on the 3rd cycle, counter never exceeds 1.
